// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - shared TPU defaults and output-stage state encodings
package result_serializer_pkg;

    // Dimensions shared with input_control and the PE array
    localparam int D_W       = 8;
    localparam int N_DEF     = 2;
    localparam int ACC_W_DEF = 2 * D_W;

    // Output-stage FSM encodings (kept as plain constants for legacy RTL that uses them)
    localparam logic [1:0] OUT_IDLE  = 2'b00;
    localparam logic [1:0] OUT_SHIFT = 2'b01;
    localparam logic [1:0] OUT_DONE  = 2'b10;

    typedef logic [1:0] out_state_t;

    // Counter width able to index n items; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_serializer_if.sv
// rtl/result_serializer_if.sv - result capture and serial pin bundle of the output stage
interface result_serializer_if #(
    parameter int N     = 2,
    parameter int ACC_W = 16
) ();

    logic [N*N*ACC_W-1:0] res_flat;
    logic                 res_valid;
    logic                 shift_en;
    logic                 data_out;
    logic                 out_valid;
    logic                 frame_start;
    logic                 busy;
    logic                 overrun;

    modport slave (
        input  res_flat, res_valid, shift_en,
        output data_out, out_valid, frame_start, busy, overrun
    );

    modport master (
        output res_flat, res_valid, shift_en,
        input  data_out, out_valid, frame_start, busy, overrun
    );

endinterface

// File: rtl/result_serializer_piso_shift.sv
// rtl/result_serializer_piso_shift.sv - parallel-load, shift-right, LSB-out register
module piso_shift #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    output logic         dout
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Load wins over shift; shifting fills zeros from the top
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (shift) begin
            q_d = {1'b0, q_q[W-1:1]};
        end
    end

    // Register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign dout = q_q[0];

endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - snapshots the PE array results and shifts them out bit-serially
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    result_serializer_if.slave  bus
);

    localparam int W   = N * N * ACC_W;
    localparam int BCW = cnt_w(ACC_W);
    localparam int WCW = cnt_w(N * N);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(ACC_W - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(N * N - 1);

    out_state_t     state_q,    state_d;
    logic [BCW-1:0] bit_cnt_q,  bit_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           overrun_q,  overrun_d;

    logic           load;
    logic           consume;
    logic           sreg_lsb;

    // A capture is only accepted from IDLE; a bit is consumed when the host allows it
    assign load    = (state_q == OUT_IDLE) && bus.res_valid;
    assign consume = (state_q == OUT_SHIFT) && bus.shift_en;

    // Frame sequencing: capture, count bits/words while consuming, one-cycle separator
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        overrun_d  = overrun_q;
        case (state_q)
            OUT_IDLE: begin
                if (bus.res_valid) begin
                    state_d    = OUT_SHIFT;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            OUT_SHIFT: begin
                if (bus.res_valid) begin
                    overrun_d = 1'b1;
                end
                if (consume) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d = '0;
                            state_d    = OUT_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            OUT_DONE: begin
                if (bus.res_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = OUT_IDLE;
            end
            default: begin
                state_d = OUT_IDLE;
            end
        endcase
    end

    // State, counters and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OUT_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    piso_shift #(
        .W (W)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (bus.res_flat),
        .shift (consume),
        .dout  (sreg_lsb)
    );

    // Outputs decode only flops, so they hold while shift_en is low and clear with reset
    assign bus.out_valid   = (state_q == OUT_SHIFT);
    assign bus.data_out    = bus.out_valid & sreg_lsb;
    assign bus.frame_start = bus.out_valid && (bit_cnt_q == '0) && (word_cnt_q == '0);
    assign bus.busy        = (state_q != OUT_IDLE);
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - randomized self-checking bench for result_serializer
module tb_result_serializer;

    localparam int N     = 2;
    localparam int ACC_W = 16;
    localparam int NB    = N * N * ACC_W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    result_serializer_if #(.N(N), .ACC_W(ACC_W)) bus ();

    result_serializer #(.N(N), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic          obs_dout, obs_ov, obs_fs, obs_busy, obs_ovr;
    logic [NB-1:0] got;
    int            col_cnt, col_cycles, col_fs_err, col_hold_err;
    bit            col_pulse;

    // Expected serial stream: words in index order, each word LSB first
    function automatic logic [NB-1:0] model_stream(input logic [NB-1:0] flat);
        bit            q[$];
        logic [ACC_W-1:0] w;
        logic [NB-1:0] s;
        for (int k = 0; k < N * N; k++) begin
            w = flat[k*ACC_W +: ACC_W];
            for (int b = 0; b < ACC_W; b++) q.push_back(((w >> b) & 1) != 0);
        end
        s = '0;
        for (int i = 0; i < NB; i++) s[i] = q[i];
        return s;
    endfunction

    // Sample this cycle's outputs at the falling edge, then drive this cycle's inputs
    task automatic cyc(input logic se, input logic rv, input logic [NB-1:0] flat);
        @(negedge clk);
        obs_dout = bus.data_out;
        obs_ov   = bus.out_valid;
        obs_fs   = bus.frame_start;
        obs_busy = bus.busy;
        obs_ovr  = bus.overrun;
        bus.shift_en  = se;
        bus.res_valid = rv;
        bus.res_flat  = flat;
    endtask

    // Consume bits base..stop-1 into got; mode 0 always enabled, 1 toggling, 2 random
    task automatic collect(input int mode, input int base, input int stop, input int rv_pct, input int budget);
        logic se, rv, prev_se, prev_ov, prev_d;
        logic [NB-1:0] junk;
        col_cnt = base; col_cycles = 0; col_fs_err = 0; col_hold_err = 0; col_pulse = 0;
        prev_se = 1'b1; prev_ov = 1'b0; prev_d = 1'b0;
        while (col_cnt < stop && col_cycles < budget) begin
            case (mode)
                0:       se = 1'b1;
                1:       se = (col_cycles % 2) == 0;
                default: se = ($urandom_range(3) != 0);
            endcase
            rv = (rv_pct > 0) && ($urandom_range(99) < rv_pct);
            junk = {$urandom, $urandom};
            if (rv) col_pulse = 1;
            cyc(se, rv, rv ? junk : bus.res_flat);
            col_cycles++;
            if (obs_ov) begin
                if (obs_fs !== (col_cnt == 0)) col_fs_err++;
                if (!prev_se && prev_ov && obs_dout !== prev_d) col_hold_err++;
                if (se) begin
                    got[col_cnt] = obs_dout;
                    col_cnt++;
                end
            end
            prev_se = se; prev_ov = obs_ov; prev_d = obs_dout;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.shift_en = 0; bus.res_valid = 0; bus.res_flat = '0;
        repeat (3) cyc(0, 0, '0);
        n_cmp++;
        if ({obs_dout, obs_ov, obs_fs, obs_busy, obs_ovr} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=00000", {obs_dout, obs_ov, obs_fs, obs_busy, obs_ovr});
        end
        rst_n = 1'b1;
        cyc(0, 0, '0);
    endtask

    task automatic test_basic();
        logic [NB-1:0] flat = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        cyc(0, 1, flat);
        collect(0, 0, NB, 0, 200);
        n_cmp++;
        if (col_cycles !== NB) begin
            n_bad++; $display("FAIL basic_cycles got=%0d exp=%0d", col_cycles, NB);
        end
        n_cmp++;
        if (got !== model_stream(flat)) begin
            n_bad++; $display("FAIL basic_bits got=%h exp=%h", got, model_stream(flat));
        end
        n_cmp++;
        if (col_fs_err !== 0) begin
            n_bad++; $display("FAIL basic_frame_start errors=%0d exp=0", col_fs_err);
        end
        cyc(1, 0, flat);
        n_cmp++;
        if ({obs_ov, obs_busy} !== 2'b01) begin
            n_bad++; $display("FAIL basic_done got=%b exp=01", {obs_ov, obs_busy});
        end
        cyc(0, 0, flat);
        n_cmp++;
        if ({obs_busy, obs_ovr} !== 2'b00) begin
            n_bad++; $display("FAIL basic_idle got=%b exp=00", {obs_busy, obs_ovr});
        end
    endtask

    task automatic test_toggle();
        logic [NB-1:0] flat = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        cyc(0, 1, flat);
        collect(1, 0, NB, 0, 400);
        n_cmp++;
        if (got !== model_stream(flat)) begin
            n_bad++; $display("FAIL toggle_bits got=%h exp=%h", got, model_stream(flat));
        end
        n_cmp++;
        if (col_hold_err !== 0) begin
            n_bad++; $display("FAIL toggle_hold errors=%0d exp=0", col_hold_err);
        end
        n_cmp++;
        if (col_cycles !== 2 * NB - 1) begin
            n_bad++; $display("FAIL toggle_cycles got=%0d exp=%0d", col_cycles, 2 * NB - 1);
        end
        cyc(0, 0, flat);
        cyc(0, 0, flat);
    endtask

    task automatic test_overrun();
        logic [NB-1:0] a = {$urandom, $urandom};
        logic [NB-1:0] b = {$urandom, $urandom};
        cyc(0, 1, a);
        collect(0, 0, 20, 0, 100);
        cyc(1, 1, ~a);
        got[20] = obs_dout;
        collect(0, 21, NB, 0, 200);
        n_cmp++;
        if (obs_ovr !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set got=%b exp=1", obs_ovr);
        end
        n_cmp++;
        if (got !== model_stream(a)) begin
            n_bad++; $display("FAIL overrun_bits got=%h exp=%h", got, model_stream(a));
        end
        cyc(0, 0, b);
        cyc(0, 0, b);
        n_cmp++;
        if ({obs_busy, obs_ovr} !== 2'b01) begin
            n_bad++; $display("FAIL overrun_sticky got=%b exp=01", {obs_busy, obs_ovr});
        end
        cyc(0, 1, b);
        cyc(0, 0, b);
        n_cmp++;
        if ({obs_ov, obs_ovr} !== 2'b10) begin
            n_bad++; $display("FAIL overrun_clear got=%b exp=10", {obs_ov, obs_ovr});
        end
        collect(0, 0, NB, 0, 200);
        n_cmp++;
        if (got !== model_stream(b)) begin
            n_bad++; $display("FAIL overrun_next_bits got=%h exp=%h", got, model_stream(b));
        end
        cyc(0, 0, b);
        cyc(0, 0, b);
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] c = {$urandom, $urandom};
        logic [NB-1:0] d = {$urandom, $urandom};
        cyc(0, 1, c);
        collect(0, 0, 33, 0, 100);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.data_out, bus.out_valid, bus.frame_start, bus.busy, bus.overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got=%b exp=00000",
                     {bus.data_out, bus.out_valid, bus.frame_start, bus.busy, bus.overrun});
        end
        cyc(0, 0, d);
        cyc(0, 0, d);
        rst_n = 1'b1;
        cyc(0, 1, d);
        collect(0, 0, NB, 0, 200);
        n_cmp++;
        if (got !== model_stream(d) || col_fs_err !== 0) begin
            n_bad++; $display("FAIL reset_mid_fresh got=%h exp=%h fs_err=%0d", got, model_stream(d), col_fs_err);
        end
        cyc(0, 0, d);
        cyc(0, 0, d);
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] ones = '1;
        logic [NB-1:0] zeros = '0;
        cyc(0, 1, ones);
        collect(0, 0, NB, 0, 200);
        n_cmp++;
        if (got !== model_stream(ones)) begin
            n_bad++; $display("FAIL b2b_ones got=%h exp=%h", got, model_stream(ones));
        end
        cyc(1, 1, zeros);
        n_cmp++;
        if ({obs_ov, obs_busy} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_done got=%b exp=01", {obs_ov, obs_busy});
        end
        cyc(0, 0, zeros);
        n_cmp++;
        if ({obs_busy, obs_ovr} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_flag got=%b exp=01", {obs_busy, obs_ovr});
        end
        cyc(0, 1, zeros);
        collect(0, 0, NB, 0, 200);
        n_cmp++;
        if (got !== model_stream(zeros) || obs_ovr !== 1'b0) begin
            n_bad++; $display("FAIL b2b_zeros got=%h ovr=%b exp=0 ovr=0", got, obs_ovr);
        end
        cyc(0, 0, zeros);
        cyc(0, 0, zeros);
    endtask

    task automatic test_random();
        logic [NB-1:0]    snap;
        logic [ACC_W-1:0] w;
        int               word_err;
        for (int f = 0; f < 200; f++) begin
            snap = {$urandom, $urandom};
            repeat ($urandom_range(2)) cyc(0, 0, snap);
            cyc(0, 1, snap);
            collect(2, 0, NB, 2, 1000);
            word_err = 0;
            for (int k = 0; k < N * N; k++) begin
                w = '0;
                for (int b = 0; b < ACC_W; b++) w = w | (ACC_W'(got[k*ACC_W + b]) << b);
                if (w !== snap[k*ACC_W +: ACC_W]) word_err++;
            end
            n_cmp++;
            if (word_err != 0 || col_cnt != NB || col_hold_err != 0 || col_fs_err != 0) begin
                n_bad++;
                $display("FAIL random_frame f=%0d words_bad=%0d bits=%0d hold_err=%0d fs_err=%0d exp 0/%0d/0/0",
                         f, word_err, col_cnt, col_hold_err, col_fs_err, NB);
            end
            cyc($urandom_range(1), 0, bus.res_flat);
            cyc(0, 0, bus.res_flat);
            n_cmp++;
            if ({obs_busy, obs_ovr} !== {1'b0, col_pulse}) begin
                n_bad++; $display("FAIL random_overrun f=%0d got=%b exp=%b", f, {obs_busy, obs_ovr}, {1'b0, col_pulse});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
